cs_sched: RTL and testbench

CS_SCHED -- requirements
Module: cs_sched

---
 rtl/cs_sched_if.sv | 31 +++
 rtl/cs_sched.sv | 113 +++++++++++
 tb/tb_cs_sched.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cs_sched_if.sv
// cs_sched_if: parser, FIFO level, register-write and status bundle.
// master = scheduler side, slave = environment side.
interface cs_sched_if;
  logic [11:0] fifo_cnt;
  logic        fs;
  logic        fd;
  logic        parse_rst;
  logic [71:0] cmd_vec;
  logic        wr_req;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic [7:0]  err_cnt;
  logic [1:0]  err_code;

  modport master (
    input  fifo_cnt, fd, cmd_vec, wr_ack,
    output fs, parse_rst, wr_req, wr_addr,
    output wr_data, busy, frame_cnt,
    output err_cnt, err_code
  );

  modport slave (
    output fifo_cnt, fd, cmd_vec, wr_ack,
    input  fs, parse_rst, wr_req, wr_addr,
    input  wr_data, busy, frame_cnt,
    input  err_cnt, err_code
  );
endinterface

// File: rtl/cs_sched.sv
// cs_sched: starts parser frames, applies 9 command bytes as register writes.
// Ports: clk, rst (async high), bus (cs_sched_if.master).
module cs_sched #(
  parameter int FRAME_LEN = 12,
  parameter int TMO       = 64,
  parameter int RST_LEN   = 2
) (
  input logic       clk,
  input logic       rst,
  cs_sched_if.master bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT_FD = 3'd1;
  localparam logic [2:0] REL     = 3'd2;
  localparam logic [2:0] WRITE   = 3'd3;
  localparam logic [2:0] RECOV   = 3'd4;

  localparam logic [11:0] FLEN     = 12'(FRAME_LEN);
  localparam logic [7:0]  TMO_LAST = 8'(TMO - 1);
  localparam logic [7:0]  RST_LAST = 8'(RST_LEN - 1);

  logic [2:0]  state;
  logic [7:0]  timer;
  logic [3:0]  idx;
  logic [71:0] shadow;
  logic [7:0]  frame_q;
  logic [7:0]  err_q;
  logic [1:0]  code_q;
  logic [6:0]  bsel;

  assign bsel = {idx, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      idx     <= '0;
      shadow  <= '0;
      frame_q <= '0;
      err_q   <= '0;
      code_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.fifo_cnt >= FLEN) begin
            state <= WAIT_FD;
            timer <= '0;
          end
        end
        WAIT_FD: begin
          // fd wins over a timeout on the same edge
          if (bus.fd) begin
            shadow <= bus.cmd_vec;
            state  <= REL;
            timer  <= '0;
          end else if (timer == TMO_LAST) begin
            state  <= RECOV;
            timer  <= '0;
            code_q <= 2'd1;
            if (err_q != 8'hff) err_q <= err_q + 8'd1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        REL: begin
          if (!bus.fd) begin
            state <= WRITE;
            idx   <= '0;
          end else if (timer == TMO_LAST) begin
            state  <= RECOV;
            timer  <= '0;
            code_q <= 2'd2;
            if (err_q != 8'hff) err_q <= err_q + 8'd1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        WRITE: begin
          if (bus.wr_ack) begin
            if (idx == 4'd8) begin
              state   <= IDLE;
              frame_q <= frame_q + 8'd1;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        RECOV: begin
          // timer reused as the recovery pulse counter
          if (timer == RST_LAST) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fs        = (state == WAIT_FD);
  assign bus.parse_rst = (state == RECOV);
  assign bus.wr_req    = (state == WRITE);
  assign bus.busy      = (state != IDLE);
  assign bus.wr_addr   = idx;
  assign bus.wr_data   = shadow[bsel +: 8];
  assign bus.frame_cnt = frame_q;
  assign bus.err_cnt   = err_q;
  assign bus.err_code  = code_q;

endmodule

// File: tb/tb_cs_sched.sv
// tb_cs_sched: random frames against a scoreboard of expected writes/errors.
// Driver pushes expectations, negedge monitor pops and compares.
module tb_cs_sched;
  localparam int TMO     = 64;
  localparam int RST_LEN = 2;
  localparam logic [71:0] PAT = 72'h090807060504030201;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cs_sched_if bus();

  cs_sched #(
    .FRAME_LEN(12),
    .TMO(TMO),
    .RST_LEN(RST_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wr_t        wr_q[$];
  int         fs_q[$];
  logic [1:0] err_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_frames;
  logic [7:0] exp_err;
  logic [1:0] exp_code;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic void model_err(logic [1:0] c);
    exp_code = c;
    if (exp_err != 8'hff) exp_err = exp_err + 8'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(bit fixed);
    bus.cmd_vec = fixed ? PAT :
      72'({$urandom(), $urandom(), $urandom()});
    bus.wr_ack = 1'($urandom() % 2);
  endtask

  // monitor: checks every presented write, fs width, recovery pulses
  initial begin : mon
    int fsw;
    int prw;
    logic prev_pr;
    fsw = 0;
    prw = 0;
    prev_pr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fsw = 0;
        prw = 0;
        prev_pr = 1'b0;
      end else begin
        if (bus.wr_req) begin
          n_cmp++;
          if (wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL wr_unexpected: addr %0d data %0h, none due",
                     bus.wr_addr, bus.wr_data);
          end else begin
            chk("wr_addr", bus.wr_addr, wr_q[0].a);
            chk("wr_data", bus.wr_data, wr_q[0].d);
            if (bus.wr_ack) void'(wr_q.pop_front());
          end
        end
        if (bus.fs) begin
          fsw++;
        end else if (fsw > 0) begin
          n_cmp++;
          if (fs_q.size() == 0) begin
            n_fail++;
            $display("FAIL fs_unexpected: width %0d, none due", fsw);
          end else begin
            n_cmp--;
            chk("fs_width", fsw, fs_q.pop_front());
          end
          fsw = 0;
        end
        if (bus.parse_rst) begin
          if (!prev_pr) begin
            n_cmp++;
            if (err_q.size() == 0) begin
              n_fail++;
              $display("FAIL recov_unexpected: code %0d, none due",
                       bus.err_code);
            end else begin
              n_cmp--;
              chk("err_code_entry", bus.err_code, err_q.pop_front());
            end
          end
          prw++;
        end else if (prw > 0) begin
          chk("parse_rst_width", prw, RST_LEN);
          prw = 0;
        end
        prev_pr = bus.parse_rst;
      end
    end
  end

  task automatic check_reset_outs();
    chk("rst_fs", bus.fs, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_req", bus.wr_req, 0);
    chk("rst_parse_rst", bus.parse_rst, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_err_code", bus.err_code, 0);
  endtask

  // d: cycles of fs before fd; h: fd high cycles; mode: 0 rnd,
  // 1 every third, 2 always ack; abort>0 resets after that many writes
  task automatic run_frame(int d, int h, int mode, bit fixed, int abort);
    logic [71:0] cap;
    wr_t w;
    int cyc;
    int acc;
    int n;
    bit capt;
    bit taken;
    cyc = 0;
    acc = 0;
    capt = (d < TMO);
    bus.fd = 1'b0;
    bus.cmd_vec = fixed ? PAT : bus.cmd_vec;
    bus.fifo_cnt = 12'($urandom_range(4095, 12));
    fs_q.push_back(capt ? d + 1 : TMO);
    step();
    chk("fs_rise", bus.fs, 1);
    bus.fifo_cnt = 12'($urandom_range(11, 0));
    if (!capt) begin
      err_q.push_back(2'd1);
      model_err(2'd1);
    end else begin
      for (int t = 0; t < d; t++) begin
        drive_rand(fixed);
        step();
      end
      drive_rand(fixed);
      cap = bus.cmd_vec;
      bus.fd = 1'b1;
      step();
      if (h <= TMO) begin
        for (int k = 0; k < 9; k++) begin
          w.a = 4'(k);
          w.d = cap[8*k +: 8];
          wr_q.push_back(w);
        end
        exp_frames = exp_frames + 8'd1;
      end else begin
        err_q.push_back(2'd2);
        model_err(2'd2);
      end
      for (int t = 1; t < h; t++) begin
        drive_rand(fixed);
        step();
      end
      bus.fd = 1'b0;
    end
    n = 0;
    while (bus.busy && n < 3000) begin
      if (!fixed)
        bus.cmd_vec = 72'({$urandom(), $urandom(), $urandom()});
      case (mode)
        0: bus.wr_ack = 1'($urandom() % 2);
        1: bus.wr_ack = (cyc % 3 == 2);
        default: bus.wr_ack = 1'b1;
      endcase
      taken = bus.wr_req && bus.wr_ack;
      step();
      n++;
      cyc++;
      if (taken) acc++;
      if (abort > 0 && acc == abort && bus.busy) begin
        rst = 1'b1;
        #1;
        check_reset_outs();
        wr_q.delete();
        exp_frames = '0;
        exp_err = '0;
        exp_code = '0;
        bus.wr_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        return;
      end
    end
    bus.wr_ack = 1'b0;
    chk("idle_reached", bus.busy, 0);
    chk("frame_cnt", bus.frame_cnt, exp_frames);
    chk("err_cnt", bus.err_cnt, exp_err);
    chk("err_code", bus.err_code, exp_code);
    chk("writes_drained", wr_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int h;
    rst = 1'b1;
    bus.fifo_cnt = '0;
    bus.fd = 1'b0;
    bus.cmd_vec = '0;
    bus.wr_ack = 1'b0;
    exp_frames = '0;
    exp_err = '0;
    exp_code = '0;
    #12;
    check_reset_outs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    bus.fifo_cnt = 12'd11;
    for (int i = 0; i < 100; i++) begin
      bus.wr_ack = 1'($urandom() % 2);
      step();
      chk("short_fifo_fs", bus.fs, 0);
      chk("short_fifo_busy", bus.busy, 0);
    end
    bus.wr_ack = 1'b0;

    run_frame(3, 1, 2, 1'b1, 0);
    run_frame(TMO, 1, 0, 1'b0, 0);
    run_frame(2, 70, 0, 1'b0, 0);
    run_frame(1, 1, 1, 1'b0, 0);
    run_frame(TMO - 1, 1, 2, 1'b0, 0);
    run_frame(0, TMO, 0, 1'b0, 0);
    run_frame(0, TMO + 1, 0, 1'b0, 0);
    run_frame(2, 1, 2, 1'b0, 4);
    run_frame(2, 1, 2, 1'b1, 0);

    for (int i = 0; i < 150; i++) begin
      d = ($urandom() % 10 < 8) ? $urandom_range(5, 0) :
          (($urandom() % 2 == 0) ? TMO - 1 : TMO);
      h = ($urandom() % 10 < 9) ? $urandom_range(3, 1) :
          TMO + $urandom_range(1, 0);
      run_frame(d, h, $urandom_range(2, 0), 1'b0, 0);
    end

    for (int i = 0; i < 256; i++)
      run_frame(0, 1, 2, 1'b0, 0);

    for (int i = 0; i < 260; i++)
      run_frame(TMO, 1, 0, 1'b0, 0);
    chk("err_cnt_saturated", bus.err_cnt, 8'hff);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule
